perf_counter_bank: RTL

Synthesizable, parametrised event-counter bank replacing the bench-only hit/request/instruction tallies with in-design hardware.
- Counts NUM_CH independent single-bit event strobes (icache req/hit, dcache req/hit, retired inst, ...) plus a free-running cycle counter.
- Freezes on processor halt.
- Exposes all counts through a registered read port, so the bench or a debug path can dump them.
- Sits beside the processor top, fed by per-stage strobes.

---
 rtl/perf_pkg.sv | 17 +
 rtl/perf_cnt.sv | 33 +++
 rtl/perf_counter_bank.sv | 128 ++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } perfState_e;

    // Conventional channel assignment for the processor event strobes.
    localparam int unsigned CH_ICREQ = 0;
    localparam int unsigned CH_ICHIT = 1;
    localparam int unsigned CH_DCREQ = 2;
    localparam int unsigned CH_DCHIT = 3;
    localparam int unsigned CH_INST  = 4;

endpackage

// File: rtl/perf_cnt.sv
// Single event counter with synchronous clear, optional saturation and a sticky overflow flag.
module perf_cnt #(
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (&count) begin
                ovf <= 1'b1;
                if (!SATURATE) begin
                    count <= '0;
                end
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Event counter bank: NUM_CH event channels plus a cycle counter, IDLE/RUN/FROZEN control and a
// registered read port. Define PERFCNT_SNAPSHOT_EN to build shadow registers behind the read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned SEL_W    = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              clr,
    input  logic [NUM_CH-1:0] event_in,
    input  logic              snap,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH:0]   ovf,
    output logic              running,
    output logic              frozen
);

    localparam int unsigned NCNT = NUM_CH + 1;

    perfState_e       stateQ, stateD;
    logic             countEn;
    logic [NCNT-1:0]  incVec;
    logic [CNT_W-1:0] liveCnt [NCNT];
    logic [CNT_W-1:0] readSrc [NCNT];
    logic [CNT_W-1:0] rdNext;

    always_comb begin
        stateD = stateQ;
        if (clr) begin
            stateD = IDLE;
        end else begin
            unique case (stateQ)
                IDLE:    if (start) stateD = RUN;
                RUN:     if (halt)  stateD = FROZEN;
                FROZEN:  stateD = FROZEN;
                default: stateD = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // The halt cycle itself is still in RUN, so its increments land.
    assign countEn = (stateQ == RUN);
    assign running = (stateQ == RUN);
    assign frozen  = (stateQ == FROZEN);

    for (genvar gi = 0; gi < NCNT; gi++) begin : gCnt
        if (gi < NUM_CH) begin : gEvt
            assign incVec[gi] = countEn & event_in[gi];
        end else begin : gCyc
            assign incVec[gi] = countEn;
        end

        perf_cnt #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) uCnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (incVec[gi]),
            .count (liveCnt[gi]),
            .ovf   (ovf[gi])
        );
    end

`ifdef PERFCNT_SNAPSHOT_EN
    logic [CNT_W-1:0] shadowQ [NCNT];
    logic             autoSnapQ;

    // Final counts only settle one edge after entering FROZEN, so the auto-snapshot is deferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            autoSnapQ <= 1'b0;
            for (int i = 0; i < int'(NCNT); i++) shadowQ[i] <= '0;
        end else if (clr) begin
            autoSnapQ <= 1'b0;
            for (int i = 0; i < int'(NCNT); i++) shadowQ[i] <= '0;
        end else begin
            autoSnapQ <= (stateQ == RUN) && (stateD == FROZEN);
            if (snap || autoSnapQ) begin
                for (int i = 0; i < int'(NCNT); i++) shadowQ[i] <= liveCnt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NCNT); i++) readSrc[i] = shadowQ[i];
    end
`else
    logic unusedSnap;
    assign unusedSnap = snap;

    always_comb begin
        for (int i = 0; i < int'(NCNT); i++) readSrc[i] = liveCnt[i];
    end
`endif

    always_comb begin
        rdNext = '0;
        for (int i = 0; i < int'(NCNT); i++) begin
            if (rd_sel == SEL_W'(i)) rdNext = readSrc[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rdNext;
        end
    end

endmodule
